// File: rtl/axil_pkg.sv
// Shared types and constants for the two-requester AXI-Lite request arbiter.
package axil_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WRITE_AW_W = 3'd1,
      WRITE_B    = 3'd2,
      READ_AR    = 3'd3,
      READ_R     = 3'd4
   } axil_state_t;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   localparam int unsigned MAX_WAIT = 5;

   // Requester index of a one-hot grant (two requesters).
   function automatic logic gnt_idx(input logic [1:0] gnt);
      return gnt[1];
   endfunction

endpackage

// File: rtl/axil_req_arbiter_if.sv
// Requester-side and AXI-Lite master-side signals of the arbiter, bundled.
interface axil_req_arbiter_if #(
   parameter int DW = 32,
   parameter int AW = 8
);
   logic [1:0]      REQ_VALID;
   logic [1:0]      REQ_WRITE;
   logic [2*AW-1:0] REQ_ADDR;
   logic [2*DW-1:0] REQ_WDATA;
   logic [1:0]      REQ_READY;
   logic [1:0]      RSP_VALID;
   logic [DW-1:0]   RSP_RDATA;
   logic [1:0]      RSP_RESP;

   logic [AW-1:0]   AXI_AWADDR;
   logic            AXI_AWVALID;
   logic            AXI_AWREADY;
   logic [DW-1:0]   AXI_WDATA;
   logic            AXI_WVALID;
   logic            AXI_WREADY;
   logic [1:0]      AXI_BRESP;
   logic            AXI_BVALID;
   logic            AXI_BREADY;
   logic [AW-1:0]   AXI_ARADDR;
   logic            AXI_ARVALID;
   logic            AXI_ARREADY;
   logic [DW-1:0]   AXI_RDATA;
   logic            AXI_RVALID;
   logic            AXI_RREADY;

   modport master (
      input  REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA,
      input  AXI_AWREADY, AXI_WREADY, AXI_BRESP, AXI_BVALID,
      input  AXI_ARREADY, AXI_RDATA, AXI_RVALID,
      output REQ_READY, RSP_VALID, RSP_RDATA, RSP_RESP,
      output AXI_AWADDR, AXI_AWVALID, AXI_WDATA, AXI_WVALID, AXI_BREADY,
      output AXI_ARADDR, AXI_ARVALID, AXI_RREADY
   );

   modport slave (
      output REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA,
      output AXI_AWREADY, AXI_WREADY, AXI_BRESP, AXI_BVALID,
      output AXI_ARREADY, AXI_RDATA, AXI_RVALID,
      input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_RESP,
      input  AXI_AWADDR, AXI_AWVALID, AXI_WDATA, AXI_WVALID, AXI_BREADY,
      input  AXI_ARADDR, AXI_ARVALID, AXI_RREADY
   );

   modport monitor (
      input REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA,
      input REQ_READY, RSP_VALID, RSP_RDATA, RSP_RESP,
      input AXI_AWADDR, AXI_AWVALID, AXI_AWREADY, AXI_WDATA, AXI_WVALID, AXI_WREADY,
      input AXI_BRESP, AXI_BVALID, AXI_BREADY,
      input AXI_ARADDR, AXI_ARVALID, AXI_ARREADY, AXI_RDATA, AXI_RVALID, AXI_RREADY
   );
endinterface

// File: rtl/axil_checker.sv
// Protocol assertions on the AXI-Lite master port and requester pulses.
module axil_checker (
   input logic clk,
   input logic rstn,
   axil_req_arbiter_if.monitor bus
);
   aw_hold: assert property (@(posedge clk) disable iff (!rstn)
      bus.AXI_AWVALID && !bus.AXI_AWREADY |=> bus.AXI_AWVALID && $stable(bus.AXI_AWADDR))
      else $error("axil_checker: AWVALID or AWADDR changed before AWREADY");

   w_hold: assert property (@(posedge clk) disable iff (!rstn)
      bus.AXI_WVALID && !bus.AXI_WREADY |=> bus.AXI_WVALID && $stable(bus.AXI_WDATA))
      else $error("axil_checker: WVALID or WDATA changed before WREADY");

   ar_hold: assert property (@(posedge clk) disable iff (!rstn)
      bus.AXI_ARVALID && !bus.AXI_ARREADY |=> bus.AXI_ARVALID && $stable(bus.AXI_ARADDR))
      else $error("axil_checker: ARVALID or ARADDR changed before ARREADY");

   rsp_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot0(bus.RSP_VALID))
      else $error("axil_checker: RSP_VALID not one-hot");

   gnt_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot0(bus.REQ_READY))
      else $error("axil_checker: REQ_READY not one-hot");
endmodule

// File: rtl/axil_rr_arb.sv
// Two-way round-robin grant: a lone request always wins, prio breaks ties.
module axil_rr_arb (
   input  logic [1:0] req,
   input  logic       prio,
   output logic [1:0] gnt
);
   // Grant decode.
   always_comb begin
      gnt[0] = req[0] & (~req[1] | ~prio);
      gnt[1] = req[1] & (~req[0] |  prio);
   end
endmodule

// File: rtl/axil_req_arbiter.sv
// Arbitrates two requesters onto one AXI-Lite master, one transaction at a time.
module axil_req_arbiter
   import axil_pkg::*;
#(
   parameter int C_AXI_DATA_WIDTH = 32,
   parameter int C_AXI_ADDR_WIDTH = 8
) (
   input logic AXI_ACLK,
   input logic AXI_ARESETN,
   axil_req_arbiter_if.master bus
);
   localparam int DW = C_AXI_DATA_WIDTH;
   localparam int AW = C_AXI_ADDR_WIDTH;

   axil_state_t   state_q, state_d;
   logic          prio_q;
   logic [1:0]    owner_q;
   logic [1:0]    req_s, gnt_s;
   logic          sel_s, wr_s;
   logic [AW-1:0] addr_s;
   logic [DW-1:0] wdata_s;
   logic          awvalid_q, wvalid_q, arvalid_q;
   logic [AW-1:0] awaddr_q, araddr_q;
   logic [DW-1:0] wdata_q, rsp_rdata_q;
   logic [1:0]    rsp_resp_q, rsp_valid_q;

   // Requests are only seen while idle, so other requesters wait out a transaction.
   always_comb begin
      if ((state_q == IDLE) && AXI_ARESETN) begin
         req_s = bus.REQ_VALID;
      end else begin
         req_s = 2'b00;
      end
      sel_s   = gnt_idx(gnt_s);
      wr_s    = bus.REQ_WRITE[sel_s];
      addr_s  = bus.REQ_ADDR[(sel_s ? AW : 0) +: AW];
      wdata_s = bus.REQ_WDATA[(sel_s ? DW : 0) +: DW];
   end

   axil_rr_arb u_rr_arb (
      .req  (req_s),
      .prio (prio_q),
      .gnt  (gnt_s)
   );

   // State register.
   always_ff @(posedge AXI_ACLK) begin
      if (!AXI_ARESETN) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (gnt_s == 2'b00) state_d = IDLE;
            else if (wr_s)      state_d = WRITE_AW_W;
            else                state_d = READ_AR;
         end
         WRITE_AW_W: begin
            if ((!awvalid_q || bus.AXI_AWREADY) && (!wvalid_q || bus.AXI_WREADY)) state_d = WRITE_B;
            else state_d = WRITE_AW_W;
         end
         WRITE_B: begin
            if (bus.AXI_BVALID) state_d = IDLE;
            else                state_d = WRITE_B;
         end
         READ_AR: begin
            if (bus.AXI_ARREADY) state_d = READ_R;
            else                 state_d = READ_AR;
         end
         READ_R: begin
            if (bus.AXI_RVALID) state_d = IDLE;
            else                state_d = READ_R;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output decode: every AXI VALID and payload comes straight from a register.
   always_comb begin
      bus.REQ_READY   = gnt_s;
      bus.RSP_VALID   = rsp_valid_q;
      bus.RSP_RDATA   = rsp_rdata_q;
      bus.RSP_RESP    = rsp_resp_q;
      bus.AXI_AWADDR  = awaddr_q;
      bus.AXI_AWVALID = awvalid_q;
      bus.AXI_WDATA   = wdata_q;
      bus.AXI_WVALID  = wvalid_q;
      bus.AXI_BREADY  = (state_q == WRITE_B);
      bus.AXI_ARADDR  = araddr_q;
      bus.AXI_ARVALID = arvalid_q;
      bus.AXI_RREADY  = (state_q == READ_R);
   end

   // Transaction datapath: latch on grant, drop each VALID after its handshake, capture response.
   always_ff @(posedge AXI_ACLK) begin
      if (!AXI_ARESETN) begin
         prio_q      <= 1'b0;
         owner_q     <= 2'b00;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         awaddr_q    <= {AW{1'b0}};
         araddr_q    <= {AW{1'b0}};
         wdata_q     <= {DW{1'b0}};
         rsp_rdata_q <= {DW{1'b0}};
         rsp_resp_q  <= 2'b00;
         rsp_valid_q <= 2'b00;
      end else begin
         rsp_valid_q <= 2'b00;
         case (state_q)
            IDLE: begin
               if (gnt_s != 2'b00) begin
                  prio_q  <= gnt_s[0];
                  owner_q <= gnt_s;
                  if (wr_s) begin
                     awaddr_q  <= addr_s;
                     wdata_q   <= wdata_s;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                  end else begin
                     araddr_q  <= addr_s;
                     arvalid_q <= 1'b1;
                  end
               end
            end
            WRITE_AW_W: begin
               if (bus.AXI_AWREADY) awvalid_q <= 1'b0;
               if (bus.AXI_WREADY)  wvalid_q  <= 1'b0;
            end
            WRITE_B: begin
               if (bus.AXI_BVALID) begin
                  rsp_resp_q  <= bus.AXI_BRESP;
                  rsp_valid_q <= owner_q;
               end
            end
            READ_AR: begin
               if (bus.AXI_ARREADY) arvalid_q <= 1'b0;
            end
            READ_R: begin
               if (bus.AXI_RVALID) begin
                  rsp_rdata_q <= bus.AXI_RDATA;
                  rsp_resp_q  <= OKAY;
                  rsp_valid_q <= owner_q;
               end
            end
            default: rsp_valid_q <= 2'b00;
         endcase
      end
   end
endmodule
